knn_seq_ctrl: RTL and testbench
===============================

KNN_SEQ_CTRL -- requirements
Module: knn_seq_ctrl

Interface
REQ-001 Parameter W, default 8: bit width of the query and of each database entry.
REQ-002 Parameter K, default 2: number of nearest neighbours retained.
REQ-003 Parameter N, default 4: number of database entries per query.
REQ-004 Local LOGW = floor(log2(W))+1, the distance width (4 for W=8).
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a query.
REQ-008 query  in  W  query word, sampled on an accepted start.
REQ-009 in_valid  in  1  database entry on in_data is valid.
REQ-010 in_data  in  W  database entry.
REQ-011 in_ready  out  1  block accepts an entry this cycle.
REQ-012 busy  out  1  high in LOAD, RUN or DONE.
REQ-013 done  out  1  one-cycle pulse when the result is final.
REQ-014 result_val  out  W*K  slot i at bits [W*(i+1)-1:W*i]; slot 0 is nearest.
REQ-015 result_dist  out  LOGW*K  slot i at bits [LOGW*(i+1)-1:LOGW*i].

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; LOAD SHALL be the IDLE->RUN transition cycle, not a separate state.
REQ-017 IDLE with start=1: query register <= query; every value slot <= 0; every distance slot <= all ones; entry counter <= 0; next state RUN.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a beat transfers when in_valid && in_ready.
REQ-020 in_valid=0 in RUN SHALL stall: slots, counter and state are held.
REQ-021 Distance of a beat SHALL be popcount(query ^ in_data), zero-extended to LOGW bits.
REQ-022 Insertion: new entry goes to the lowest slot i whose stored distance is strictly greater than the new distance; slots i..K-2 shift to i+1; slot K-1 is discarded.
REQ-023 No stored distance greater than the new distance: slots SHALL be unchanged.
REQ-024 Ties SHALL keep the earlier-arrived entry in the lower slot.
REQ-025 Slot distances SHALL remain non-decreasing from slot 0 to K-1 at all times.
REQ-026 Each transfer SHALL increment the counter; the transfer taking it to N SHALL move the state to DONE next cycle.
REQ-027 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-028 result_val and result_dist SHALL be driven from the slot registers and hold after DONE until the next accepted start.
REQ-029 K > N: unfilled slots SHALL keep value 0 and distance all ones.
REQ-030 Throughput SHALL be one entry per cycle; a query with no stalls SHALL complete in N+2 cycles from start to done.
REQ-031 The counter SHALL be wide enough to hold N without wrap-around.

Reset
REQ-032 rst_n=0 SHALL force, asynchronously, state IDLE, in_ready=0, busy=0, done=0, counter=0, query register=0, all value slots=0 and all distance slots=all ones.
REQ-033 Reset asserted mid-query SHALL abandon that query, with no done pulse.

Verification (W=8, K=2, N=4)
REQ-034 Query 0x00, entries 0x01, 0xFF, 0x03, 0x80 with no stalls -> done on cycle 6 after start; result_val=0x8001; result_dist=0x11.
REQ-035 Same stream with in_valid low for 3 cycles between beats 2 and 3 -> identical result; done is delayed 3 cycles; slots are held during the stall.
REQ-036 Query 0xF0, entries 0xF0, 0xF0, 0x00, 0xF1 -> result_val=0xF0F0 (earlier tie wins; 0xF1 discarded); result_dist=0x00.
REQ-037 start pulsed again during RUN -> ignored; result unchanged; no extra done pulse.
REQ-038 rst_n low after beat 2 -> outputs go to reset values immediately; a new start then runs cleanly to the correct result.
REQ-039 K=6 with N=4, query 0x00, entries 0x01, 0x03, 0x07, 0x0F -> slots 0..3 = 0x01, 0x03, 0x07, 0x0F with distances 1..4; slots 4..5 = 0x00 with distance 0xF.

Source files
------------

// File: rtl/knn_seq_ctrl.sv
// Streaming k-nearest-neighbour selector: keeps the K database entries closest
// to a query in Hamming distance, as a sorted slot array (slot 0 nearest).
module knn_seq_ctrl #(
  parameter int W = 8,
  parameter int K = 2,
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [W-1:0]               query,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       done,
  output logic [W*K-1:0]             result_val,
  output logic [$clog2(W+1)*K-1:0]   result_dist
);

  localparam int LOGW = $clog2(W + 1);
  localparam int CW   = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    query_q, query_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    val_q  [K];
  logic [W-1:0]    val_d  [K];
  logic [LOGW-1:0] dist_q [K];
  logic [LOGW-1:0] dist_d [K];
  logic [LOGW-1:0] new_dist;
  logic [K-1:0]    gt;

  function automatic logic [LOGW-1:0] popcount(input logic [W-1:0] x);
    logic [LOGW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + LOGW'(x[i]);
    return c;
  endfunction

  // Slots are kept sorted, so gt is a thermometer code: every slot from the
  // insertion point upward is strictly farther than the new beat.
  always_comb begin
    new_dist = popcount(query_q ^ in_data);
    for (int i = 0; i < K; i++) gt[i] = (dist_q[i] > new_dist);
  end

  // Next-state logic: load on start, ordered insertion per beat, done pulse.
  always_comb begin
    state_d = state_q;
    query_d = query_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < K; i++) begin
      val_d[i]  = val_q[i];
      dist_d[i] = dist_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          query_d = query;
          cnt_d   = '0;
          state_d = S_RUN;
          for (int i = 0; i < K; i++) begin
            val_d[i]  = '0;
            dist_d[i] = '1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          val_d[0]  = gt[0] ? in_data  : val_q[0];
          dist_d[0] = gt[0] ? new_dist : dist_q[0];
          for (int i = 1; i < K; i++) begin
            val_d[i]  = gt[i-1] ? val_q[i-1]  : (gt[i] ? in_data  : val_q[i]);
            dist_d[i] = gt[i-1] ? dist_q[i-1] : (gt[i] ? new_dist : dist_q[i]);
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and slot registers with asynchronous reset to the empty result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      query_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < K; i++) begin
        val_q[i]  <= '0;
        dist_q[i] <= '1;
      end
    end else begin
      state_q <= state_d;
      query_q <= query_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < K; i++) begin
        val_q[i]  <= val_d[i];
        dist_q[i] <= dist_d[i];
      end
    end
  end

  // Busy also covers the load cycle, which is IDLE with start asserted.
  assign in_ready = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) || (start && rst_n);

  always_comb begin
    for (int i = 0; i < K; i++) begin
      result_val[W*i +: W]        = val_q[i];
      result_dist[LOGW*i +: LOGW] = dist_q[i];
    end
  end

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl: a stable-sort reference model checked
// every cycle on K=2 and K=6 instances, plus directed literal scenarios.
module tb_knn_seq_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  query = 8'h00;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready2, busy2, done2;
  logic [15:0] rv2;
  logic [7:0]  rd2;
  logic        in_ready6, busy6, done6;
  logic [47:0] rv6;
  logic [23:0] rd6;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 done; entries in arrival order
  int         phase = 0;
  int         cnt = 0;
  logic [7:0] mq = 8'h00;
  logic [7:0] ents[$];

  knn_seq_ctrl #(.W(8), .K(2), .N(N)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .query(query),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .busy(busy2), .done(done2), .result_val(rv2), .result_dist(rd2)
  );

  knn_seq_ctrl #(.W(8), .K(6), .N(N)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .query(query),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready6),
    .busy(busy6), .done(done6), .result_val(rv6), .result_dist(rd6)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected slots: stable sort of all received entries by Hamming distance, first k kept
  function automatic void model_out(input int k, output logic [47:0] v, output logic [23:0] d);
    logic [7:0] s[$];
    logic [7:0] t;
    s = ents;
    for (int i = 1; i < s.size(); i++)
      for (int j = i; j > 0 && $countones(mq ^ s[j-1]) > $countones(mq ^ s[j]); j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    v = '0;
    d = '0;
    for (int j = 0; j < k; j++) begin
      if (j < s.size()) begin
        v[8*j +: 8] = s[j];
        d[4*j +: 4] = 4'($countones(mq ^ s[j]));
      end else begin
        d[4*j +: 4] = 4'hF;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      cnt   <= 0;
      mq    <= 8'h00;
      ents.delete();
    end else begin
      case (phase)
        0: if (start) begin
             phase <= 1; mq <= query; cnt <= 0; ents.delete();
           end
        1: if (in_valid) begin
             ents.push_back(in_data);
             cnt <= cnt + 1;
             if (cnt + 1 == N) phase <= 2;
           end
        2: phase <= 0;
        default: phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    logic [47:0] v;
    logic [23:0] d;
    logic        eb;
    eb = (phase != 0) || (start && rst_n);
    model_out(2, v, d);
    check("rv2", 64'(rv2), 64'(v[15:0]));
    check("rd2", 64'(rd2), 64'(d[7:0]));
    check("in_ready2", 64'(in_ready2), 64'(phase == 1));
    check("busy2", 64'(busy2), 64'(eb));
    check("done2", 64'(done2), 64'(phase == 2));
    model_out(6, v, d);
    check("rv6", 64'(rv6), 64'(v));
    check("rd6", 64'(rd6), 64'(d));
    check("done6", 64'(done6), 64'(phase == 2));
    check("in_ready6", 64'(in_ready6), 64'(phase == 1));
  end

  task automatic cyc(input logic s, input logic [7:0] q, input logic v, input logic [7:0] d);
    start = s; query = q; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  // One query of four beats; optional stall before beat stall_at and stray start on beat start_at
  task automatic run_q(input logic [7:0] q, input logic [31:0] es, input int stall_at,
                       input int stall_len, input int start_at,
                       input logic [15:0] mid_v, input logic [7:0] mid_d);
    cyc(1'b1, q, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) cyc(1'b0, 8'h00, 1'b0, 8'h5A);
        check("stall_hold_val", 64'(rv2), 64'(mid_v));
        check("stall_hold_dist", 64'(rd2), 64'(mid_d));
      end
      cyc(i == start_at, 8'hAA, 1'b1, es[8*i +: 8]);
    end
    check("done_pulse", 64'(done2), 64'd1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    check("done_single", 64'(done2), 64'd0);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] q);
    case ($urandom_range(0, 3))
      0: return q ^ 8'(1 << $urandom_range(0, 7));
      1: return q;
      2: return q ^ 8'h0F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ready", 64'(in_ready2), 64'd0);
    check("reset_busy", 64'(busy2), 64'd0);
    check("reset_val", 64'(rv6), 64'd0);
    check("reset_dist", 64'(rd6), 64'hFF_FFFF);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 8'h00);

    run_q(8'h00, {8'h80, 8'h03, 8'hFF, 8'h01}, -1, 0, -1, 16'h0, 8'h0);
    check("basic_val", 64'(rv2), 64'h8001);
    check("basic_dist", 64'(rd2), 64'h11);

    run_q(8'h00, {8'h80, 8'h03, 8'hFF, 8'h01}, 2, 3, -1, 16'hFF01, 8'h81);
    check("stall_val", 64'(rv2), 64'h8001);
    check("stall_dist", 64'(rd2), 64'h11);

    run_q(8'hF0, {8'hF1, 8'h00, 8'hF0, 8'hF0}, -1, 0, -1, 16'h0, 8'h0);
    check("tie_val", 64'(rv2), 64'hF0F0);
    check("tie_dist", 64'(rd2), 64'h00);

    run_q(8'h00, {8'h80, 8'h03, 8'hFF, 8'h01}, -1, 0, 2, 16'h0, 8'h0);
    check("start_ignored_val", 64'(rv2), 64'h8001);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    check("held_after_done", 64'(rv2), 64'h8001);

    cyc(1'b1, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 8'hFF);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(in_ready2), 64'd0);
    check("midrst_busy", 64'(busy2), 64'd0);
    check("midrst_done", 64'(done2), 64'd0);
    check("midrst_val", 64'(rv2), 64'h0);
    check("midrst_dist", 64'(rd2), 64'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_q(8'h00, {8'h80, 8'h03, 8'hFF, 8'h01}, -1, 0, -1, 16'h0, 8'h0);
    check("after_rst_val", 64'(rv2), 64'h8001);

    run_q(8'h00, {8'h0F, 8'h07, 8'h03, 8'h01}, -1, 0, -1, 16'h0, 8'h0);
    check("k6_val", 64'(rv6), 64'h0000_0F07_0301);
    check("k6_dist", 64'(rd6), 64'hFF_4321);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] q;
      logic       v;
      int         beats;
      q = 8'($urandom);
      cyc(1'b1, q, 1'b0, 8'h00);
      beats = 0;
      while (beats < N) begin
        if ($urandom_range(0, 24) == 0) begin
          start = 1'b0; in_valid = 1'b0; rst_n = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          break;
        end
        v = ($urandom_range(0, 9) < 7);
        cyc($urandom_range(0, 7) == 0, 8'($urandom), v, pick(q));
        if (v) beats++;
      end
      repeat ($urandom_range(1, 3)) cyc(1'b0, 8'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
